opll_write_sequencer: RTL and testbench
=======================================

Name: opll_write_sequencer

Overview:
- Sits directly downstream of the FM-PAC cartridge mapper pair. Collects OPLL register writes from two sources:
  - memory-mapped strobes (opll_wr[1:0]);
  - I/O port writes to 7Ch/7Dh, gated by opll_io_enable[1:0].
- Queues the writes in a small FIFO and replays them to the YM2413 core with the mandatory settle time between writes: 12 OPLL clocks after an address write, 84 after a data write.
- Lets the Z80 write at full bus speed without corrupting OPLL register state.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..32.
- ADDR_WAIT, 12, OPLL clock-enable pulses held off after an address (A0=0) write.
- DATA_WAIT, 84, OPLL clock-enable pulses held off after a data (A0=1) write.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ce_opll  in  1  OPLL clock enable, one clk wide (3.58 MHz rate).
- addr  in  16  CPU address bus.
- d_from_cpu  in  8  CPU write data.
- wr  in  1  CPU write strobe.
- iorq  in  1  CPU I/O request.
- opll_wr  in  2  per-cartridge memory-mapped OPLL write pulse from the mapper; bit n = slot n.
- opll_io_enable  in  2  per-cartridge I/O port enable from the mapper.
- opll_we  out  1  write strobe to the OPLL core, one clk wide, coincident with ce_opll.
- opll_a0  out  1  register address (0) / data (1) select.
- opll_dout  out  8  write data to the OPLL core.
- opll_sel  out  2  target OPLL instance mask.
- busy  out  1  FIFO non-empty or wait counter running.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset (async, reset_n=0): FIFO empty, skid register empty, FSM IDLE, counter 0. All outputs 0: opll_we, opll_a0, opll_dout, opll_sel, busy, overflow.
- Entry format is 11 bits: {sel[1:0], a0, data[7:0]}.
- Memory-mapped capture:
  - Trigger: any opll_wr bit high.
  - Entry = {opll_wr, addr[0], d_from_cpu}, sampled in that cycle. The mapper holds addr/data for the full write cycle.
- I/O capture:
  - Trigger: rising edge of (wr & iorq & addr[7:1]==7'h3E & |opll_io_enable). Exactly one capture per bus cycle.
  - Entry = {opll_io_enable, addr[0], d_from_cpu}. sel is the mask of enabled cartridges; both can be hit.
- Simultaneous memory-mapped and I/O captures in the same cycle:
  - The memory-mapped entry is pushed first.
  - The I/O entry goes into a 1-entry skid register and is pushed on the next cycle. The skid register has priority over new captures.
  - A capture arriving while the skid register is occupied and the FIFO is full is dropped and sets overflow.
- FIFO full: the push is dropped, overflow sets to 1 and stays 1 until reset. Existing contents are never overwritten.
- FSM states:
  - IDLE: on FIFO non-empty, go to ISSUE.
  - ISSUE: wait for ce_opll=1. In that cycle, pulse opll_we=1, drive the head entry on opll_a0/opll_dout/opll_sel, pop the FIFO, load the counter (a0 ? DATA_WAIT : ADDR_WAIT) and go to WAIT.
  - WAIT: decrement the counter on each ce_opll. When it reaches 0, go to ISSUE if the FIFO is non-empty, else IDLE.
- opll_a0, opll_dout and opll_sel hold their last issued values between strobes.
- Minimum spacing between opll_we strobes is wait+1 ce_opll pulses.
- Counter width is clog2(max(ADDR_WAIT, DATA_WAIT))+1 bits. No wrap is possible.
- busy = FIFO non-empty | skid occupied | state != IDLE.
- Push and pop in the same cycle are both honoured; occupancy is unchanged. A push into a full FIFO in the same cycle as a pop succeeds.
- Reset mid-wait discards the queue and the counter with no further opll_we.

Optional Feature:
- OPLL_WRITE_IO_PORT_EN
  - Defined: I/O port 7Ch/7Dh capture and the skid register are built as described.
  - Undefined: only memory-mapped opll_wr is captured, the skid register is removed, and iorq and opll_io_enable are ignored. The ports remain present so the instantiation is unchanged.

Decomposition:
- Shared package msx_opll_pkg:
  - typedef opll_wr_entry_t (struct: sel[1:0], a0, data[7:0]);
  - constants OPLL_IO_PORT_BASE=8'h7C, OPLL_ADDR_WAIT_DEF=12, OPLL_DATA_WAIT_DEF=84.
- One sub-module: opll_wr_fifo, a synchronous FIFO parameterised by DEPTH and entry type, with full/empty flags and simultaneous push/pop support.

Test Plan:
- Address write: opll_wr=01, addr=7FF4, data=10 -> exactly one opll_we on the next ce_opll with a0=0, dout=10, sel=01. Next strobe is no earlier than 12 ce_opll pulses later.
- Address then data: mem write 7FF4=30 then 7FF5=A5 back-to-back -> strobes at ce k and k+13. After the data write, busy stays high for 84 more ce_opll, then drops to 0.
- I/O write: opll_io_enable=11, OUT 7Dh=55 held 4 clk -> one entry {sel=11, a0=1, data=55}. No duplicate capture.
- Simultaneous capture: opll_wr=10 and the I/O edge in the same clk -> memory-mapped entry issued first, I/O entry second, both intact.
- Overflow (DEPTH=8): 10 writes with ce_opll held low -> first 8 issued in order once ce resumes, last 2 dropped, overflow=1 until reset_n.
- Reset mid-wait: assert reset_n=0 during a DATA_WAIT count -> all outputs 0 immediately. After release, no strobes until a new write.

Source files
------------

// File: rtl/msx_opll_pkg.sv
// Shared types and constants for the MSX OPLL write path.
// Entry layout {sel, a0, data} is common to the capture logic and the replay FIFO.
package msx_opll_pkg;

    typedef struct packed {
        logic [1:0] sel;
        logic       a0;
        logic [7:0] data;
    } opll_wr_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_t;

    localparam logic [7:0] OPLL_IO_PORT_BASE  = 8'h7C;
    localparam int         OPLL_ADDR_WAIT_DEF = 12;
    localparam int         OPLL_DATA_WAIT_DEF = 84;

endpackage

// File: rtl/opll_wr_fifo.sv
// Synchronous FIFO with full/empty flags; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module opll_wr_fifo #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic [10:0]
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/opll_write_sequencer.sv
// Queues OPLL register writes and replays them with the YM2413 settle time.
// Define OPLL_WRITE_IO_PORT_EN to add I/O port 7Ch/7Dh capture and the skid register.
module opll_write_sequencer
    import msx_opll_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ADDR_WAIT = OPLL_ADDR_WAIT_DEF,
    parameter int DATA_WAIT = OPLL_DATA_WAIT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_opll,
    input  logic [15:0] addr,
    input  logic [7:0]  d_from_cpu,
    input  logic        wr,
    input  logic        iorq,
    input  logic [1:0]  opll_wr,
    input  logic [1:0]  opll_io_enable,
    output logic        opll_we,
    output logic        opll_a0,
    output logic [7:0]  opll_dout,
    output logic [1:0]  opll_sel,
    output logic        busy,
    output logic        overflow
);

    localparam int MAX_WAIT = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int CW       = $clog2(MAX_WAIT) + 1;

    opll_wr_entry_t mem_entry, push_data, head, last_q;
    logic           mem_trig, push, pop, can_push, drop, skid_busy;
    logic           fifo_full, fifo_empty, issue, overflow_q;
    seq_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    assign mem_trig  = |opll_wr;
    assign mem_entry = {opll_wr, addr[0], d_from_cpu};
    assign pop       = issue;
    assign can_push  = ~fifo_full | pop;

`ifdef OPLL_WRITE_IO_PORT_EN
    opll_wr_entry_t io_entry, skid_q, skid_d;
    logic           io_hit, io_hit_q, io_trig, skid_valid_q, skid_valid_d;
    logic           unused_bits;

    assign unused_bits = ^addr[15:8];
    assign io_hit      = wr & iorq & (addr[7:1] == OPLL_IO_PORT_BASE[7:1]) & (|opll_io_enable);
    assign io_trig     = io_hit & ~io_hit_q;
    assign io_entry    = {opll_io_enable, addr[0], d_from_cpu};
    assign skid_busy   = skid_valid_q;

    // The skid entry drains first; with the skid busy, a new mem-mapped capture
    // takes the freed slot and a coincident I/O capture is lost.
    always_comb begin
        push         = 1'b0;
        push_data    = mem_entry;
        drop         = 1'b0;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (skid_valid_q) begin
            if (can_push) begin
                push      = 1'b1;
                push_data = skid_q;
                if (mem_trig) begin
                    skid_d = mem_entry;
                    drop   = io_trig;
                end else if (io_trig) begin
                    skid_d = io_entry;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else begin
                drop = mem_trig | io_trig;
            end
        end else if (mem_trig) begin
            push = 1'b1;
            drop = ~can_push;
            if (io_trig) begin
                skid_valid_d = 1'b1;
                skid_d       = io_entry;
            end
        end else if (io_trig) begin
            push      = 1'b1;
            push_data = io_entry;
            drop      = ~can_push;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            io_hit_q     <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            io_hit_q     <= io_hit;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end
`else
    logic unused_bits;

    assign unused_bits = ^{iorq, wr, opll_io_enable, addr[15:1]};
    assign push        = mem_trig;
    assign push_data   = mem_entry;
    assign drop        = mem_trig & ~can_push;
    assign skid_busy   = 1'b0;
`endif

    opll_wr_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (opll_wr_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (ce_opll) begin
                    issue   = 1'b1;
                    cnt_d   = head.a0 ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ce_opll) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) last_q <= head;
            if (drop)  overflow_q <= 1'b1;
        end
    end

    // The head entry is shown in the strobe cycle, then held until the next one.
    assign opll_we   = issue;
    assign opll_a0   = issue ? head.a0   : last_q.a0;
    assign opll_dout = issue ? head.data : last_q.data;
    assign opll_sel  = issue ? head.sel  : last_q.sel;
    assign busy      = ~fifo_empty | skid_busy | (state_q != ST_IDLE);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_opll_write_sequencer.sv
// Bench for opll_write_sequencer: table of single writes plus multi-cycle sequences.
// Covers the I/O capture path when OPLL_WRITE_IO_PORT_EN is defined.
module tb_opll_write_sequencer;
    import msx_opll_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_opll = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  d_from_cpu = '0;
    logic        wr = 1'b0;
    logic        iorq = 1'b0;
    logic [1:0]  opll_wr = '0;
    logic [1:0]  opll_io_enable = '0;
    logic        opll_we, opll_a0, busy, overflow;
    logic [7:0]  opll_dout;
    logic [1:0]  opll_sel;

    opll_write_sequencer dut (
        .clk(clk), .reset_n(reset_n), .ce_opll(ce_opll), .addr(addr),
        .d_from_cpu(d_from_cpu), .wr(wr), .iorq(iorq), .opll_wr(opll_wr),
        .opll_io_enable(opll_io_enable), .opll_we(opll_we), .opll_a0(opll_a0),
        .opll_dout(opll_dout), .opll_sel(opll_sel), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mw;
        logic [15:0] a;
        logic [7:0]  d;
        logic [10:0] exp;
        int          wait_ce;
    } vec_t;

    vec_t        tbl [5];
    logic [10:0] exp_q [$];
    int          vec_cnt = 0;
    int          miss_cnt = 0;
    int          ce_idx = 0;
    int          n_strobes = 0;
    int          last_strobe_ce = 0;
    int          phase = 0;
    bit          ce_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, observe 1 ns later.
    task automatic tick(input logic [1:0] mw, input logic [15:0] a, input logic [7:0] d);
        logic [10:0] e;
        @(negedge clk);
        phase      = (phase + 1) % 4;
        ce_opll    = ce_en && (phase == 0);
        opll_wr    = mw;
        addr       = a;
        d_from_cpu = d;
        #1;
        if (ce_opll) ce_idx++;
        if (opll_we) begin
            n_strobes++;
            last_strobe_ce = ce_idx;
            check("we_with_ce", 32'(ce_opll), 32'd1);
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("strobe_entry", 32'({opll_sel, opll_a0, opll_dout}), 32'(e));
            end
        end
    endtask

    task automatic wait_strobes(input int target, input int budget_ce);
        int c = 0;
        while (n_strobes < target && c < budget_ce * 4) begin
            tick(2'b00, addr, 8'h00);
            c++;
        end
        check("strobe_timeout", 32'(n_strobes >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget_ce);
        int c = 0;
        while (busy && c < budget_ce * 4) begin
            tick(2'b00, addr, 8'h00);
            c++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 32'({opll_we, opll_a0, opll_dout, opll_sel, busy, overflow}), 32'd0);
    endtask

    initial begin
        int base, s1, s2;

        tbl[0] = '{2'b01, 16'h7FF4, 8'h10, {2'b01, 1'b0, 8'h10}, 12};
        tbl[1] = '{2'b10, 16'h7FF5, 8'hA5, {2'b10, 1'b1, 8'hA5}, 84};
        tbl[2] = '{2'b11, 16'h7FF4, 8'h3C, {2'b11, 1'b0, 8'h3C}, 12};
        tbl[3] = '{2'b01, 16'h0001, 8'hFF, {2'b01, 1'b1, 8'hFF}, 84};
        tbl[4] = '{2'b10, 16'hBFF4, 8'h00, {2'b10, 1'b0, 8'h00}, 12};

        repeat (3) tick(2'b00, 16'h0000, 8'h00);
        check_all_zero("reset_state");
        reset_n = 1'b1;
        repeat (4) tick(2'b00, 16'h0000, 8'h00);
        check_all_zero("idle_after_reset");

        foreach (tbl[i]) begin
            base = n_strobes;
            exp_q.push_back(tbl[i].exp);
            tick(tbl[i].mw, tbl[i].a, tbl[i].d);
            wait_strobes(base + 1, 40);
            s1 = last_strobe_ce;
            tick(2'b00, 16'h0000, 8'h00);
            check("held_outputs", 32'({opll_sel, opll_a0, opll_dout}), 32'(tbl[i].exp));
            wait_idle(200);
            check("wait_len", 32'(ce_idx - s1), 32'(tbl[i].wait_ce));
            check("single_strobe", 32'(n_strobes - base), 32'd1);
        end

        // Address then data back to back.
        base = n_strobes;
        exp_q.push_back({2'b01, 1'b0, 8'h30});
        exp_q.push_back({2'b01, 1'b1, 8'hA5});
        tick(2'b01, 16'h7FF4, 8'h30);
        tick(2'b01, 16'h7FF5, 8'hA5);
        wait_strobes(base + 1, 40);
        s1 = last_strobe_ce;
        wait_strobes(base + 2, 40);
        s2 = last_strobe_ce;
        check("addr_data_spacing", 32'(s2 - s1), 32'd13);
        wait_idle(200);
        check("data_busy_len", 32'(ce_idx - s2), 32'd84);

`ifdef OPLL_WRITE_IO_PORT_EN
        base = n_strobes;
        exp_q.push_back({2'b11, 1'b1, 8'h55});
        opll_io_enable = 2'b11; wr = 1'b1; iorq = 1'b1;
        repeat (4) tick(2'b00, 16'h007D, 8'h55);
        wr = 1'b0; iorq = 1'b0;
        wait_strobes(base + 1, 40);
        wait_idle(200);
        check("io_single_capture", 32'(n_strobes - base), 32'd1);

        base = n_strobes;
        exp_q.push_back({2'b10, 1'b1, 8'h55});
        exp_q.push_back({2'b01, 1'b1, 8'h55});
        opll_io_enable = 2'b01; wr = 1'b1; iorq = 1'b1;
        tick(2'b10, 16'h007D, 8'h55);
        repeat (3) tick(2'b00, 16'h007D, 8'h55);
        wr = 1'b0; iorq = 1'b0; opll_io_enable = 2'b00;
        wait_strobes(base + 2, 120);
        wait_idle(200);
        check("simul_count", 32'(n_strobes - base), 32'd2);
`else
        base = n_strobes;
        opll_io_enable = 2'b11; wr = 1'b1; iorq = 1'b1;
        repeat (4) tick(2'b00, 16'h007D, 8'h55);
        wr = 1'b0; iorq = 1'b0; opll_io_enable = 2'b00;
        repeat (3) tick(2'b00, 16'h0000, 8'h00);
        check("io_ignored_busy", 32'(busy), 32'd0);
        repeat (40) tick(2'b00, 16'h0000, 8'h00);
        check("io_ignored_strobes", 32'(n_strobes - base), 32'd0);
`endif

        // Overflow: ten writes while the OPLL clock is stalled.
        check("overflow_clear", 32'(overflow), 32'd0);
        base  = n_strobes;
        ce_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) exp_q.push_back({2'b01, 1'b0, 8'(i + 8'h40)});
            tick(2'b01, 16'h7FF4, 8'(i + 8'h40));
        end
        tick(2'b00, 16'h0000, 8'h00);
        check("overflow_set", 32'(overflow), 32'd1);
        check("overflow_busy", 32'(busy), 32'd1);
        ce_en = 1'b1;
        wait_strobes(base + 8, 8 * 14 + 20);
        wait_idle(200);
        check("overflow_issued", 32'(n_strobes - base), 32'd8);
        check("overflow_queue_drained", 32'(exp_q.size()), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        @(negedge clk); reset_n = 1'b0;
        #1 check("overflow_reset", 32'(overflow), 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // Reset in the middle of a data wait.
        base = n_strobes;
        exp_q.push_back({2'b10, 1'b1, 8'h77});
        tick(2'b10, 16'h7FF5, 8'h77);
        wait_strobes(base + 1, 40);
        repeat (20) tick(2'b00, 16'h0000, 8'h00);
        check("midwait_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midwait_reset");
        @(negedge clk); reset_n = 1'b1;
        repeat (400) tick(2'b00, 16'h0000, 8'h00);
        check("no_strobe_after_reset", 32'(n_strobes - base), 32'd1);
        check("idle_after_midwait", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
